// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch stream vs. one-at-a-time CPU accesses.
// Video has priority; a bounded starvation counter guarantees CPU progress.
module vram_arbiter #(
  parameter int unsigned AW         = 14,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk_ram,
  input  logic          sys_init,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic          vid_valid,
  output logic [15:0]   vid_q,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [1:0]    cpu_be,
  input  logic [15:0]   cpu_d,
  output logic          cpu_ack,
  output logic [15:0]   cpu_q,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [1:0]    ram_be,
  output logic [15:0]   ram_d,
  input  logic [15:0]   ram_q
);

  localparam int unsigned Last      = RD_LAT - 1;
  localparam logic [3:0]  StarveMax = 4'(STARVE_MAX);

  logic [3:0]        starve_q, starve_d;
  logic              cpu_lock_q, cpu_lock_d;
  logic              cpu_acked_q, cpu_acked_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_cpu_q, tag_cpu_d;
  logic [RD_LAT-1:0] tag_rd_q, tag_rd_d;
  logic [AW-1:0]     ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [1:0]        ram_be_q, ram_be_d;
  logic [15:0]       ram_d_q, ram_d_d;
  logic [15:0]       vid_hold_q, vid_hold_d;
  logic [15:0]       cpu_hold_q, cpu_hold_d;

  logic cpu_elig, grant_cpu, grant_vid, cpu_rd_ack, cpu_wr_ack;

  always_comb begin
    cpu_elig  = cpu_req & ~cpu_lock_q;
    grant_cpu = ~sys_init & cpu_elig & (~vid_req | (starve_q == StarveMax));
    grant_vid = ~sys_init & vid_req & ~grant_cpu;

    // Returns are decoded from the tag stage whose data is on ram_q now.
    vid_valid  = tag_vld_q[Last] & ~tag_cpu_q[Last];
    cpu_rd_ack = tag_vld_q[Last] & tag_cpu_q[Last] & tag_rd_q[Last];
    cpu_wr_ack = tag_vld_q[0] & tag_cpu_q[0] & ~tag_rd_q[0];
    cpu_ack    = cpu_rd_ack | cpu_wr_ack;
    vid_gnt    = grant_vid;
    vid_q      = vid_valid ? ram_q : vid_hold_q;
    cpu_q      = cpu_rd_ack ? ram_q : cpu_hold_q;
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_d_d     = ram_d_q;
    ram_we_d    = 1'b0;
    ram_be_d    = 2'b11;
    starve_d    = starve_q;
    cpu_lock_d  = cpu_lock_q;
    cpu_acked_d = cpu_acked_q;
    vid_hold_d  = vid_valid ? ram_q : vid_hold_q;
    cpu_hold_d  = cpu_rd_ack ? ram_q : cpu_hold_q;
    tag_vld_d   = tag_vld_q;
    tag_cpu_d   = tag_cpu_q;
    tag_rd_d    = tag_rd_q;

    for (int i = int'(Last); i > 0; i--) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_cpu_d[i] = tag_cpu_q[i-1];
      tag_rd_d[i]  = tag_rd_q[i-1];
    end
    tag_vld_d[0] = grant_vid | grant_cpu;
    tag_cpu_d[0] = grant_cpu;
    tag_rd_d[0]  = grant_vid | (grant_cpu & ~cpu_we);

    if (grant_vid) begin
      ram_addr_d = vid_addr;
    end else if (grant_cpu) begin
      ram_addr_d = cpu_addr;
      ram_we_d   = cpu_we;
      if (cpu_we) begin
        ram_be_d = cpu_be;
        ram_d_d  = cpu_d;
      end
    end

    if (grant_cpu) begin
      starve_d = 4'd0;
    end else if (grant_vid && cpu_elig && (starve_q != StarveMax)) begin
      starve_d = starve_q + 4'd1;
    end

    // The CPU port re-arms only after its ack and a sampled-low request.
    if (grant_cpu) begin
      cpu_lock_d  = 1'b1;
      cpu_acked_d = 1'b0;
    end else if (cpu_lock_q) begin
      if ((cpu_ack | cpu_acked_q) & ~cpu_req) begin
        cpu_lock_d  = 1'b0;
        cpu_acked_d = 1'b0;
      end else if (cpu_ack) begin
        cpu_acked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_ram or posedge sys_init) begin
    if (sys_init) begin
      starve_q    <= 4'd0;
      cpu_lock_q  <= 1'b0;
      cpu_acked_q <= 1'b0;
      tag_vld_q   <= '0;
      tag_cpu_q   <= '0;
      tag_rd_q    <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= 2'b11;
      ram_d_q     <= 16'h0000;
      vid_hold_q  <= 16'h0000;
      cpu_hold_q  <= 16'h0000;
    end else begin
      starve_q    <= starve_d;
      cpu_lock_q  <= cpu_lock_d;
      cpu_acked_q <= cpu_acked_d;
      tag_vld_q   <= tag_vld_d;
      tag_cpu_q   <= tag_cpu_d;
      tag_rd_q    <= tag_rd_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_be_q    <= ram_be_d;
      ram_d_q     <= ram_d_d;
      vid_hold_q  <= vid_hold_d;
      cpu_hold_q  <= cpu_hold_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_we   = ram_we_q;
  assign ram_be   = ram_be_q;
  assign ram_d    = ram_d_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a synchronous one-register-read RAM model (RD_LAT=2).
// RAM preload: mem[a] = a ^ 16'h5A00.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        sys_init;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic        vid_gnt, vid_valid;
  logic [15:0] vid_q;
  logic        cpu_req, cpu_we;
  logic [13:0] cpu_addr;
  logic [1:0]  cpu_be;
  logic [15:0] cpu_d;
  logic        cpu_ack;
  logic [15:0] cpu_q;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [1:0]  ram_be;
  logic [15:0] ram_d;
  logic [15:0] ram_q;

  int n_checks = 0;
  int n_pass   = 0;

  vram_arbiter dut (
    .clk_ram  (clk),
    .sys_init (sys_init),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_gnt  (vid_gnt),
    .vid_valid(vid_valid),
    .vid_q    (vid_q),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_be   (cpu_be),
    .cpu_d    (cpu_d),
    .cpu_ack  (cpu_ack),
    .cpu_q    (cpu_q),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_be   (ram_be),
    .ram_d    (ram_d),
    .ram_q    (ram_q)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:16383];
  logic        loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 16'(i) ^ 16'h5A00;
      loaded <= 1'b1;
    end else begin
      ram_q <= mem[ram_addr];
      if (ram_we) begin
        if (ram_be[0]) mem[ram_addr][7:0]  <= ram_d[7:0];
        if (ram_be[1]) mem[ram_addr][15:8] <= ram_d[15:8];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      vid_req = 1'b0;
      cpu_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    sys_init = 1'b1; vid_req = 1'b1; vid_addr = '0; cpu_req = 1'b1; cpu_we = 1'b0;
    cpu_addr = '0; cpu_be = 2'b00; cpu_d = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (vid_gnt !== 1'b0) $display("FAIL rst_vid_gnt: got %b want 0", vid_gnt); else n_pass++;
    n_checks++; if (vid_valid !== 1'b0) $display("FAIL rst_vid_valid: got %b want 0", vid_valid); else n_pass++;
    n_checks++; if (cpu_ack !== 1'b0) $display("FAIL rst_cpu_ack: got %b want 0", cpu_ack); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL rst_ram_we: got %b want 0", ram_we); else n_pass++;
    n_checks++; if (ram_be !== 2'b11) $display("FAIL rst_ram_be: got %b want 11", ram_be); else n_pass++;
    n_checks++; if (ram_addr !== 14'h0) $display("FAIL rst_ram_addr: got %h want 0", ram_addr); else n_pass++;
    n_checks++; if (ram_d !== 16'h0) $display("FAIL rst_ram_d: got %h want 0", ram_d); else n_pass++;
    n_checks++; if (vid_q !== 16'h0 || cpu_q !== 16'h0)
      $display("FAIL rst_q: got vid_q=%h cpu_q=%h want 0/0", vid_q, cpu_q); else n_pass++;
    cyc();
    sys_init = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
    idle(2);
  endtask

  task automatic test_video_burst();
    for (int i = 0; i < 7; i++) begin
      cyc();
      vid_req = (i < 4); vid_addr = 14'(i);
      @(negedge clk);
      n_checks++; if (vid_gnt !== (i < 4))
        $display("FAIL burst_gnt[%0d]: got %b want %b", i, vid_gnt, (i < 4)); else n_pass++;
      n_checks++; if (vid_valid !== (i >= 2 && i < 6))
        $display("FAIL burst_valid[%0d]: got %b want %b", i, vid_valid, (i >= 2 && i < 6)); else n_pass++;
      if (i >= 2 && i < 6) begin
        n_checks++; if (vid_q !== (16'h5A00 + 16'(i - 2)))
          $display("FAIL burst_q[%0d]: got %h want %h", i, vid_q, 16'h5A00 + 16'(i - 2)); else n_pass++;
      end
      if (i == 6) begin
        n_checks++; if (ram_we !== 1'b0) $display("FAIL idle_we: got %b want 0", ram_we); else n_pass++;
      end
    end
    idle(2);
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 8; i++) begin
      cyc();
      vid_req = 1'b1; vid_addr = 14'h0100 + 14'(i);
      cpu_req = (i < 7); cpu_we = 1'b0; cpu_addr = 14'h2000;
      @(negedge clk);
      n_checks++; if (vid_gnt !== (i != 4))
        $display("FAIL starve_gnt[%0d]: got %b want %b", i, vid_gnt, (i != 4)); else n_pass++;
      n_checks++; if (cpu_ack !== (i == 6))
        $display("FAIL starve_ack[%0d]: got %b want %b", i, cpu_ack, (i == 6)); else n_pass++;
      if (i == 4) begin
        n_checks++; if (dut.starve_q !== 4'd4)
          $display("FAIL starve_cnt: got %0d want 4", dut.starve_q); else n_pass++;
      end
      if (i == 5) begin
        n_checks++; if (ram_addr !== 14'h2000 || ram_we !== 1'b0)
          $display("FAIL starve_cmd: got addr=%h we=%b want 2000/0", ram_addr, ram_we); else n_pass++;
      end
      if (i == 6) begin
        n_checks++; if (cpu_q !== 16'h7A00)
          $display("FAIL starve_q: got %h want 7a00", cpu_q); else n_pass++;
      end
    end
    idle(3);
  endtask

  task automatic test_write_read();
    for (int c = 0; c < 7; c++) begin
      cyc();
      cpu_req = (c <= 1) || (c >= 3 && c <= 5); cpu_we = (c <= 1);
      cpu_addr = 14'h0010; cpu_be = 2'b10; cpu_d = 16'h1234;
      @(negedge clk);
      n_checks++; if (cpu_ack !== (c == 1 || c == 5))
        $display("FAIL wr_ack[%0d]: got %b want %b", c, cpu_ack, (c == 1 || c == 5)); else n_pass++;
      if (c == 1) begin
        n_checks++; if (ram_we !== 1'b1 || ram_be !== 2'b10 || ram_d !== 16'h1234 || ram_addr !== 14'h10)
          $display("FAIL wr_cmd: got we=%b be=%b d=%h a=%h want 1/10/1234/0010",
                   ram_we, ram_be, ram_d, ram_addr); else n_pass++;
      end
      if (c == 4) begin
        n_checks++; if (ram_we !== 1'b0 || ram_be !== 2'b11)
          $display("FAIL rd_cmd: got we=%b be=%b want 0/11", ram_we, ram_be); else n_pass++;
      end
      if (c >= 5) begin
        n_checks++; if (cpu_q !== 16'h1210)
          $display("FAIL rd_merge[%0d]: got %h want 1210", c, cpu_q); else n_pass++;
      end
    end
    idle(2);
  endtask

  task automatic test_hold_req();
    for (int i = 0; i < 13; i++) begin
      cyc();
      cpu_req = (i != 8 && i < 12); cpu_we = 1'b0; cpu_addr = 14'h0020;
      @(negedge clk);
      n_checks++; if (cpu_ack !== (i == 2 || i == 11))
        $display("FAIL hold_ack[%0d]: got %b want %b", i, cpu_ack, (i == 2 || i == 11)); else n_pass++;
      if (i == 11) begin
        n_checks++; if (cpu_q !== 16'h5A20) $display("FAIL hold_q: got %h want 5a20", cpu_q); else n_pass++;
      end
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    for (int p = 0; p < 8; p++) begin
      cyc();
      sys_init = (p == 2 || p == 4);
      vid_req  = (p < 3) && (p != 2) || (p == 2);
      vid_req  = (p <= 2);
      vid_addr = 14'h0050;
      cpu_req  = (p <= 4); cpu_we = 1'b0; cpu_addr = 14'h0030;
      @(negedge clk);
      if (p < 2) begin
        n_checks++; if (vid_gnt !== 1'b1) $display("FAIL mid_vfirst[%0d]: got %b want 1", p, vid_gnt); else n_pass++;
      end
      if (p == 1) begin
        n_checks++; if (dut.starve_q !== 4'd1)
          $display("FAIL mid_cnt_up: got %0d want 1", dut.starve_q); else n_pass++;
      end
      if (p == 2 || p == 4) begin
        n_checks++; if (vid_gnt !== 1'b0 || vid_valid !== 1'b0 || cpu_ack !== 1'b0 || ram_we !== 1'b0)
          $display("FAIL mid_pulses[%0d]: got gnt=%b vv=%b ack=%b we=%b want 0000",
                   p, vid_gnt, vid_valid, cpu_ack, ram_we); else n_pass++;
        n_checks++; if (ram_addr !== 14'h0 || ram_d !== 16'h0 || ram_be !== 2'b11)
          $display("FAIL mid_ram[%0d]: got a=%h d=%h be=%b want 0/0/11", p, ram_addr, ram_d, ram_be);
        else n_pass++;
        n_checks++; if (vid_q !== 16'h0 || cpu_q !== 16'h0)
          $display("FAIL mid_q[%0d]: got vid_q=%h cpu_q=%h want 0/0", p, vid_q, cpu_q); else n_pass++;
        n_checks++; if (dut.starve_q !== 4'd0)
          $display("FAIL mid_cnt[%0d]: got %0d want 0", p, dut.starve_q); else n_pass++;
      end
      if (p == 3 || p >= 5) begin
        n_checks++; if (cpu_ack !== 1'b0 || vid_valid !== 1'b0)
          $display("FAIL mid_stale[%0d]: got ack=%b vv=%b want 0/0", p, cpu_ack, vid_valid); else n_pass++;
      end
    end
    idle(2);
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c < 6; c++) begin
      cyc();
      vid_req = (c < 2); vid_addr = 14'h0060;
      cpu_req = (c < 5); cpu_we = 1'b0; cpu_addr = 14'h0040;
      @(negedge clk);
      if (c == 0) begin
        n_checks++; if (dut.starve_q !== 4'd0)
          $display("FAIL sim_cnt0: got %0d want 0", dut.starve_q); else n_pass++;
      end
      n_checks++; if (vid_gnt !== (c < 2))
        $display("FAIL sim_gnt[%0d]: got %b want %b", c, vid_gnt, (c < 2)); else n_pass++;
      n_checks++; if (cpu_ack !== (c == 4))
        $display("FAIL sim_ack[%0d]: got %b want %b", c, cpu_ack, (c == 4)); else n_pass++;
      if (c == 3) begin
        n_checks++; if (ram_addr !== 14'h0040 || ram_we !== 1'b0)
          $display("FAIL sim_cmd: got a=%h we=%b want 0040/0", ram_addr, ram_we); else n_pass++;
      end
      if (c == 4) begin
        n_checks++; if (cpu_q !== 16'h5A40) $display("FAIL sim_q: got %h want 5a40", cpu_q); else n_pass++;
      end
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_video_burst();
    test_starvation();
    test_write_read();
    test_hold_req();
    test_reset_mid();
    test_simultaneous();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
